memory_stage: RTL and testbench

- MEM-stage controller between the EX/MEM latch and the MEM/WB latch.
- Issues data-cache requests and holds the pipeline until the cache returns dhit.
- Maintains the LL/SC link register, handles snoop invalidation, and latches halt.
- Drives the enable for the MEM/WB latch and the stall to upstream stages.

---
 rtl/memory_stage.sv | 149 ++++++++++++++
 tb/tb_memory_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// MEM-stage controller: issues D-cache requests, tracks the LL/SC link, latches HALT.
// Latency: a hit in the request cycle completes with zero stall; each cycle dhit stays low adds one stall.
// Backpressure: stall_MEM freezes upstream while a request waits; mw_enable gates MEM/WB on completion.
//
// Ports:
//   CLK, RST                     clock and synchronous active-high reset
//   valid_MEM .. wdat_MEM        decoded instruction and operands from the EX/MEM latch
//   dhit, dload                  cache completion strobe and read data
//   ccinv, ccsnoopaddr           coherence invalidate of a word address
//   dREN, dWEN, daddr, dstore    cache request
//   mem_data, mw_enable          result and latch enable for MEM/WB
//   stall_MEM, halt_out          upstream freeze and sticky halt
//   stall_cycles                 saturating count of stalled cycles
module memory_stage #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_MEM,
    input  logic              memRd_MEM,
    input  logic              memWr_MEM,
    input  logic              ll_MEM,
    input  logic              sc_MEM,
    input  logic              halt_MEM,
    input  logic [ADDR_W-1:0] addr_MEM,
    input  logic [WORD_W-1:0] wdat_MEM,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccsnoopaddr,
    output logic              dREN,
    output logic              dWEN,
    output logic [ADDR_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] mem_data,
    output logic              stall_MEM,
    output logic              mw_enable,
    output logic              halt_out,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

    state_t              state_q, state_d;
    logic                link_valid_q, link_valid_d;
    logic [ADDR_W-1:0]   link_addr_q, link_addr_d;
    logic [WORD_W-1:0]   load_data_q, load_data_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

    logic pending;
    logic sc_fail;

    // Word-granular compare: byte offset bits are shifted out.
    function automatic logic same_word(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return ((a ^ b) >> 2) == '0;
    endfunction

    assign pending  = valid_MEM && (memRd_MEM || memWr_MEM) && (state_q != HALTED);
    assign sc_fail  = sc_MEM && (!link_valid_q || !same_word(link_addr_q, addr_MEM));
    assign halt_out = (state_q == HALTED);
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        state_d        = state_q;
        link_valid_d   = link_valid_q;
        link_addr_d    = link_addr_q;
        load_data_d    = load_data_q;
        stall_cycles_d = stall_cycles_q;
        dREN           = 1'b0;
        dWEN           = 1'b0;
        daddr          = addr_MEM;
        dstore         = wdat_MEM;
        stall_MEM      = 1'b0;
        mw_enable      = 1'b1;
        mem_data       = load_data_q;

        // Snoop clears are evaluated first so an LL completing in the same cycle wins.
        if (ccinv && same_word(ccsnoopaddr, link_addr_q))
            link_valid_d = 1'b0;

        if (state_q == HALTED) begin
            mw_enable = 1'b0;
        end else if (pending) begin
            if (sc_fail) begin
                // Failed SC never touches the cache and retires immediately with 0.
                mem_data = '0;
                state_d  = IDLE;
            end else begin
                dREN = memRd_MEM;
                dWEN = memWr_MEM;
                if (dhit) begin
                    state_d = IDLE;
                    if (sc_MEM) begin
                        mem_data     = {{(WORD_W-1){1'b0}}, 1'b1};
                        load_data_d  = {{(WORD_W-1){1'b0}}, 1'b1};
                        link_valid_d = 1'b0;
                    end else if (memRd_MEM) begin
                        mem_data    = dload;
                        load_data_d = dload;
                    end
                    if (memWr_MEM && !sc_MEM && same_word(addr_MEM, link_addr_q))
                        link_valid_d = 1'b0;
                    if (ll_MEM) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = addr_MEM;
                    end
                end else begin
                    stall_MEM = 1'b1;
                    mw_enable = 1'b0;
                    state_d   = BUSY;
                end
            end
        end else if (state_q == IDLE && valid_MEM && halt_MEM) begin
            state_d = HALTED;
        end else begin
            state_d = IDLE;
        end

        // Reset overrides the handshake outputs combinationally, even mid-request.
        if (RST) begin
            dREN      = 1'b0;
            dWEN      = 1'b0;
            stall_MEM = 1'b0;
            mw_enable = 1'b1;
        end

        if (stall_MEM && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            link_valid_q   <= 1'b0;
            link_addr_q    <= '0;
            load_data_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            link_valid_q   <= link_valid_d;
            link_addr_q    <= link_addr_d;
            load_data_q    <= load_data_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: per-cycle vector table, expectations queued at drive time.
// Latency: each vector is checked on the falling edge of the cycle it is driven in.
// Backpressure: none; the bench drives every cycle and drains the queue before the summary.
module tb_memory_stage;

    localparam int CW = 4;  // small counter so saturation is reachable quickly

    logic        CLK, RST;
    logic        valid_MEM, memRd_MEM, memWr_MEM, ll_MEM, sc_MEM, halt_MEM;
    logic [31:0] addr_MEM, wdat_MEM, dload, ccsnoopaddr;
    logic        dhit, ccinv;
    logic        dREN, dWEN, stall_MEM, mw_enable, halt_out;
    logic [31:0] daddr, dstore, mem_data;
    logic [CW-1:0] stall_cycles;

    memory_stage #(.WORD_W(32), .ADDR_W(32), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .valid_MEM(valid_MEM), .memRd_MEM(memRd_MEM), .memWr_MEM(memWr_MEM),
        .ll_MEM(ll_MEM), .sc_MEM(sc_MEM), .halt_MEM(halt_MEM),
        .addr_MEM(addr_MEM), .wdat_MEM(wdat_MEM),
        .dhit(dhit), .dload(dload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .mem_data(mem_data), .stall_MEM(stall_MEM), .mw_enable(mw_enable),
        .halt_out(halt_out), .stall_cycles(stall_cycles)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    localparam int K_IDLE = 0, K_LW = 1, K_SW = 2, K_LL = 3, K_SC = 4, K_HALT = 5, K_NV = 6;

    typedef struct packed {
        logic        rst, vld, rd, wr, ll, sc, halt;
        logic [31:0] addr, wdat;
        logic        dhit;
        logic [31:0] dload;
        logic        ccinv;
        logic [31:0] snoop;
        logic        e_dren, e_dwen, e_stall, e_mw, e_mchk;
        logic [31:0] e_mdat;
        logic        e_halt;
        logic [31:0] e_sc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t in_v(int k, logic [31:0] a, logic h, logic [31:0] ld,
                                  logic r, logic ci, logic [31:0] sa);
        vec_t v;
        v       = '0;
        v.rst   = r;
        v.vld   = (k != K_IDLE) && (k != K_NV);
        v.rd    = (k == K_LW) || (k == K_LL) || (k == K_NV);
        v.wr    = (k == K_SW) || (k == K_SC);
        v.ll    = (k == K_LL);
        v.sc    = (k == K_SC);
        v.halt  = (k == K_HALT);
        v.addr  = a;
        v.wdat  = a ^ 32'hCAFE_0000;
        v.dhit  = h;
        v.dload = ld;
        v.ccinv = ci;
        v.snoop = sa;
        return v;
    endfunction

    function automatic vec_t ex(vec_t v, logic dr, logic dw, logic st, logic mw, logic mc,
                                logic [31:0] md, logic ho, int sc);
        vec_t o;
        o         = v;
        o.e_dren  = dr;
        o.e_dwen  = dw;
        o.e_stall = st;
        o.e_mw    = mw;
        o.e_mchk  = mc;
        o.e_mdat  = md;
        o.e_halt  = ho;
        o.e_sc    = sc;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    // Scoreboard consumer: one expected record per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            chk("dREN", {31'b0, dREN}, {31'b0, e.e_dren});
            chk("dWEN", {31'b0, dWEN}, {31'b0, e.e_dwen});
            chk("stall_MEM", {31'b0, stall_MEM}, {31'b0, e.e_stall});
            chk("mw_enable", {31'b0, mw_enable}, {31'b0, e.e_mw});
            chk("halt_out", {31'b0, halt_out}, {31'b0, e.e_halt});
            chk("stall_cycles", {{(32-CW){1'b0}}, stall_cycles}, e.e_sc);
            if (e.e_mchk) chk("mem_data", mem_data, e.e_mdat);
            if (e.e_dren || e.e_dwen) chk("daddr", daddr, e.addr);
            if (e.e_dwen) chk("dstore", dstore, e.wdat);
        end
    end

    task automatic drive(input vec_t v);
        @(posedge CLK);
        #1;
        RST         = v.rst;
        valid_MEM   = v.vld;
        memRd_MEM   = v.rd;
        memWr_MEM   = v.wr;
        ll_MEM      = v.ll;
        sc_MEM      = v.sc;
        halt_MEM    = v.halt;
        addr_MEM    = v.addr;
        wdat_MEM    = v.wdat;
        dhit        = v.dhit;
        dload       = v.dload;
        ccinv       = v.ccinv;
        ccsnoopaddr = v.snoop;
        sb.push_back(v);
    endtask

    initial begin
        RST = 1'b1; valid_MEM = 0; memRd_MEM = 0; memWr_MEM = 0; ll_MEM = 0; sc_MEM = 0;
        halt_MEM = 0; addr_MEM = 0; wdat_MEM = 0; dhit = 0; dload = 0; ccinv = 0; ccsnoopaddr = 0;

        // Reset state
        tbl.push_back(ex(in_v(K_IDLE, 0, 0, 0, 1, 0, 0), 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(ex(in_v(K_IDLE, 0, 0, 0, 1, 0, 0), 0, 0, 0, 1, 1, 0, 0, 0));
        // LW 0x40 with three miss cycles
        tbl.push_back(ex(in_v(K_LW, 32'h40, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(ex(in_v(K_LW, 32'h40, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(ex(in_v(K_LW, 32'h40, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(ex(in_v(K_LW, 32'h40, 1, 32'hDEAD_BEEF, 0, 0, 0), 1, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 3));
        tbl.push_back(ex(in_v(K_IDLE, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 3));
        // SW single-cycle hit
        tbl.push_back(ex(in_v(K_SW, 32'h80, 1, 0, 0, 0, 0), 0, 1, 0, 1, 0, 0, 0, 3));
        // LL, SC success after one wait, repeated SC fails
        tbl.push_back(ex(in_v(K_LL, 32'h100, 1, 32'h55, 0, 0, 0), 1, 0, 0, 1, 1, 32'h55, 0, 3));
        tbl.push_back(ex(in_v(K_SC, 32'h100, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 3));
        tbl.push_back(ex(in_v(K_SC, 32'h100, 1, 0, 0, 0, 0), 0, 1, 0, 1, 1, 1, 0, 4));
        tbl.push_back(ex(in_v(K_SC, 32'h100, 1, 0, 0, 0, 0), 0, 0, 0, 1, 1, 0, 0, 4));
        // LL, snoop to the same word (different byte), SC fails without request
        tbl.push_back(ex(in_v(K_LL, 32'h100, 1, 32'h66, 0, 0, 0), 1, 0, 0, 1, 1, 32'h66, 0, 4));
        tbl.push_back(ex(in_v(K_IDLE, 0, 0, 0, 0, 1, 32'h102), 0, 0, 0, 1, 1, 32'h66, 0, 4));
        tbl.push_back(ex(in_v(K_SC, 32'h100, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 0, 0, 4));
        // LL hit and snoop in the same cycle: LL wins, SC succeeds
        tbl.push_back(ex(in_v(K_LL, 32'h200, 1, 32'h77, 0, 1, 32'h200), 1, 0, 0, 1, 1, 32'h77, 0, 4));
        tbl.push_back(ex(in_v(K_SC, 32'h200, 1, 0, 0, 0, 0), 0, 1, 0, 1, 1, 1, 0, 4));
        // Stray dhit with nothing pending changes nothing
        tbl.push_back(ex(in_v(K_IDLE, 0, 1, 32'h99, 0, 0, 0), 0, 0, 0, 1, 1, 1, 0, 4));
        // SW to the linked word breaks the link
        tbl.push_back(ex(in_v(K_LL, 32'h300, 1, 32'h88, 0, 0, 0), 1, 0, 0, 1, 1, 32'h88, 0, 4));
        tbl.push_back(ex(in_v(K_SW, 32'h300, 1, 0, 0, 0, 0), 0, 1, 0, 1, 0, 0, 0, 4));
        tbl.push_back(ex(in_v(K_SC, 32'h300, 1, 0, 0, 0, 0), 0, 0, 0, 1, 1, 0, 0, 4));
        // Read with valid_MEM low issues nothing
        tbl.push_back(ex(in_v(K_NV, 32'h40, 1, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0, 4));

        foreach (tbl[i]) drive(tbl[i]);

        // Reset asserted while a load is stalled
        drive(ex(in_v(K_LW, 32'h40, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0, 0, 4));
        drive(ex(in_v(K_LW, 32'h40, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0, 0, 5));
        drive(ex(in_v(K_LW, 32'h40, 0, 0, 1, 0, 0), 0, 0, 0, 1, 0, 0, 0, 6));
        drive(ex(in_v(K_IDLE, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 0, 0, 0));

        // Long stall: counter saturates at all-ones and holds
        for (int i = 0; i < 20; i++)
            drive(ex(in_v(K_LW, 32'h44, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0, 0, (i > 15) ? 15 : i));
        drive(ex(in_v(K_LW, 32'h44, 1, 32'hA5, 0, 0, 0), 1, 0, 0, 1, 1, 32'hA5, 0, 15));
        drive(ex(in_v(K_IDLE, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 32'hA5, 0, 15));

        // HALT is sticky and blocks further requests
        drive(ex(in_v(K_HALT, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 32'hA5, 0, 15));
        drive(ex(in_v(K_IDLE, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 15));
        drive(ex(in_v(K_LW, 32'h40, 1, 32'h1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 15));
        drive(ex(in_v(K_SW, 32'h80, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 15));
        drive(ex(in_v(K_HALT, 0, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 15));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d records left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
